// File: rtl/fir_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fir_ctrl_pkg
// Shared definitions for the HDMI FIR coefficient/control register block:
// register offsets, CTRL bit positions, the request FSM encoding, the unity
// gain reset coefficient and the default filter geometry.
// No ports (package).
// ---------------------------------------------------------------------------
package fir_ctrl_pkg;

   localparam int NUM_TAPS_DEF = 16;
   localparam int COEFF_W_DEF  = 16;

   localparam logic [7:0] TAP_BASE    = 8'h00;
   localparam logic [7:0] CTRL        = 8'h40;
   localparam logic [7:0] STATUS      = 8'h44;
   localparam logic [7:0] ACTIVE_BASE = 8'h80;

   localparam int CTRL_COMMIT_BIT = 0;
   localparam int CTRL_BYPASS_BIT = 1;

   // Q2.14 value of 1.0, loaded into tap 0 so the reset filter is a wire
   localparam logic [15:0] COEFF_RESET = 16'h4000;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      ACK,
      RELEASE
   } ctrlState_t;

endpackage

// File: rtl/fir_coeff_ctrl_if.sv
// ---------------------------------------------------------------------------
// fir_coeff_ctrl_if
// Four-phase strobe/ack request port between the AXI-lite slave and the
// FIR coefficient block.
//   wr_strobe_i / wr_addr_i / wr_data_i : write request level, address, data
//   wr_ack_o                            : write acknowledge level
//   rd_strobe_i / rd_addr_i             : read request level, address
//   rd_data_o / rd_ack_o                : read data (valid with ack), ack
// master = AXI-lite side, slave = coefficient block.
// ---------------------------------------------------------------------------
interface fir_coeff_ctrl_if;

   logic        wr_strobe_i;
   logic [7:0]  wr_addr_i;
   logic [31:0] wr_data_i;
   logic        wr_ack_o;
   logic        rd_strobe_i;
   logic [7:0]  rd_addr_i;
   logic [31:0] rd_data_o;
   logic        rd_ack_o;

   modport master (
      output wr_strobe_i, wr_addr_i, wr_data_i, rd_strobe_i, rd_addr_i,
      input  wr_ack_o, rd_data_o, rd_ack_o
   );

   modport slave (
      input  wr_strobe_i, wr_addr_i, wr_data_i, rd_strobe_i, rd_addr_i,
      output wr_ack_o, rd_data_o, rd_ack_o
   );

endinterface

// File: rtl/fir_coeff_bank.sv
// ---------------------------------------------------------------------------
// fir_coeff_bank
// Shadow and active coefficient arrays. Software writes land in the shadow
// bank; a swap copies the whole shadow bank into the active bank, which
// drives the filter.
//   i_clk, i_rstN         : clock, synchronous active-low reset
//   i_wrEn/i_wrIdx/i_wrData : shadow tap write port
//   i_swap                : copy shadow -> active on this edge
//   i_rdActive/i_rdIdx    : read select (active or shadow bank) and tap
//   o_rdData              : selected tap, sign-extended to 32 bits
//   o_coeff               : packed active bank, tap k at [k*COEFF_W +: COEFF_W]
// ---------------------------------------------------------------------------
module fir_coeff_bank
   import fir_ctrl_pkg::*;
#(
   parameter int NUM_TAPS = NUM_TAPS_DEF,
   parameter int COEFF_W  = COEFF_W_DEF
) (
   input  logic                         i_clk,
   input  logic                         i_rstN,
   input  logic                         i_wrEn,
   input  logic [3:0]                   i_wrIdx,
   input  logic [COEFF_W-1:0]           i_wrData,
   input  logic                         i_swap,
   input  logic                         i_rdActive,
   input  logic [3:0]                   i_rdIdx,
   output logic [31:0]                  o_rdData,
   output logic [NUM_TAPS*COEFF_W-1:0]  o_coeff
);

   logic [COEFF_W-1:0] r_shadow [NUM_TAPS];
   logic [COEFF_W-1:0] r_active [NUM_TAPS];
   logic [COEFF_W-1:0] w_rdTap;

   // Both banks come out of reset as a unity-gain pass filter. The swap reads
   // r_shadow before this edge's tap write lands, so a write racing a swap
   // stays in the shadow bank only and waits for the next commit.
   always_ff @(posedge i_clk) begin
      if (!i_rstN) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            r_shadow[k] <= (k == 0) ? COEFF_W'(COEFF_RESET) : '0;
            r_active[k] <= (k == 0) ? COEFF_W'(COEFF_RESET) : '0;
         end
      end else begin
         if (i_swap) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
               r_active[k] <= r_shadow[k];
            end
         end
         if (i_wrEn) begin
            r_shadow[i_wrIdx] <= i_wrData;
         end
      end
   end

   // Read mux: coefficients are two's complement, so software sees them
   // sign-extended to the full bus width.
   assign w_rdTap  = i_rdActive ? r_active[i_rdIdx] : r_shadow[i_rdIdx];
   assign o_rdData = {{(32-COEFF_W){w_rdTap[COEFF_W-1]}}, w_rdTap};

   // Flatten the active bank onto the filter bus.
   for (genvar k = 0; k < NUM_TAPS; k++) begin : g_coeffOut
      assign o_coeff[k*COEFF_W +: COEFF_W] = r_active[k];
   end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// ---------------------------------------------------------------------------
// fir_coeff_ctrl
// Coefficient and control register block for the HDMI FIR filter. Serves
// four-phase strobe/ack requests from the AXI-lite slave, holds CTRL/STATUS,
// and swaps the shadow coefficient bank into the active bank at a frame
// boundary once software has committed, so a frame never sees mixed taps.
//   s_axi_aclk, s_axi_aresetn : clock, synchronous active-low reset
//   bus (slave modport)       : strobe/ack request port
//   frame_start_i             : one-cycle pulse at each video frame start
//   coeff_o                   : active coefficient bank
//   coeff_upd_o               : pulse in the cycle the active bank first shows
//                               new values
//   bypass_o                  : CTRL.BYPASS
// ---------------------------------------------------------------------------
module fir_coeff_ctrl
   import fir_ctrl_pkg::*;
#(
   parameter int NUM_TAPS = NUM_TAPS_DEF,
   parameter int COEFF_W  = COEFF_W_DEF
) (
   input  logic                         s_axi_aclk,
   input  logic                         s_axi_aresetn,
   fir_coeff_ctrl_if.slave              bus,
   input  logic                         frame_start_i,
   output logic [NUM_TAPS*COEFF_W-1:0]  coeff_o,
   output logic                         coeff_upd_o,
   output logic                         bypass_o
);

   ctrlState_t  r_state;
   ctrlState_t  w_nextState;

   logic        r_isWrite;
   logic [5:0]  r_wordAddr;
   logic [15:0] r_wdata;

   logic        r_wrAck;
   logic        r_rdAck;
   logic [31:0] r_rdData;

   logic        r_commitPending;
   logic        r_bypass;
   logic [7:0]  r_swapCnt;
   logic        r_coeffUpd;

   logic        w_latch;
   logic        w_exec;
   logic        w_ackDone;
   logic        w_servedStrobe;
   logic        w_tapHit;
   logic        w_activeHit;
   logic        w_ctrlHit;
   logic        w_statusHit;
   logic        w_tapWr;
   logic        w_ctrlWr;
   logic        w_commitWr;
   logic        w_swap;
   logic [31:0] w_bankRd;
   logic [31:0] w_readValue;

   // The strobe we are waiting to see fall is the one that won arbitration.
   assign w_servedStrobe = r_isWrite ? bus.wr_strobe_i : bus.rd_strobe_i;

   // State register. Reset drops any transaction in flight; a strobe still
   // held afterwards simply looks like a fresh request in IDLE.
   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Write beats read when both strobes are up; the loser
   // is still high when we come back to IDLE and is served then. RELEASE
   // forces the ack low for a cycle so the AXI-side edge detector sees
   // every transaction as a separate pulse.
   always_comb begin
      w_nextState = r_state;
      w_latch     = 1'b0;
      w_exec      = 1'b0;
      w_ackDone   = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.wr_strobe_i || bus.rd_strobe_i) begin
               w_latch     = 1'b1;
               w_nextState = EXEC;
            end
         end
         EXEC: begin
            w_exec      = 1'b1;
            w_nextState = ACK;
         end
         ACK: begin
            if (!w_servedStrobe) begin
               w_ackDone   = 1'b1;
               w_nextState = RELEASE;
            end
         end
         RELEASE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Capture the winning request in IDLE so EXEC works from stable values.
   // Only the word address and the low half of the data are ever used.
   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         r_isWrite  <= 1'b0;
         r_wordAddr <= '0;
         r_wdata    <= '0;
      end else if (w_latch) begin
         r_isWrite  <= bus.wr_strobe_i;
         r_wordAddr <= bus.wr_strobe_i ? bus.wr_addr_i[7:2] : bus.rd_addr_i[7:2];
         r_wdata    <= bus.wr_data_i[15:0];
      end
   end

   // Address decode on the latched word address. Tap and active windows only
   // cover the implemented taps; everything else is a silent hole.
   assign w_tapHit    = (r_wordAddr[5:4] == TAP_BASE[7:6]) &&
                        ({1'b0, r_wordAddr[3:0]} < 5'(NUM_TAPS));
   assign w_activeHit = (r_wordAddr[5:4] == ACTIVE_BASE[7:6]) &&
                        ({1'b0, r_wordAddr[3:0]} < 5'(NUM_TAPS));
   assign w_ctrlHit   = (r_wordAddr == CTRL[7:2]);
   assign w_statusHit = (r_wordAddr == STATUS[7:2]);

   assign w_tapWr    = w_exec && r_isWrite && w_tapHit;
   assign w_ctrlWr   = w_exec && r_isWrite && w_ctrlHit;
   assign w_commitWr = w_ctrlWr && r_wdata[CTRL_COMMIT_BIT];

   // Swap decision uses the registered commit flag, so a COMMIT landing on
   // the same edge as frame_start waits for the following frame.
   assign w_swap = frame_start_i && r_commitPending;

   // Read data source for EXEC. COMMIT always reads back as 0.
   always_comb begin
      w_readValue = '0;
      if (w_tapHit || w_activeHit) begin
         w_readValue = w_bankRd;
      end else if (w_ctrlHit) begin
         w_readValue = 32'({r_bypass, 1'b0});
      end else if (w_statusHit) begin
         w_readValue = {16'h0000, r_swapCnt, 7'b0000000, r_commitPending};
      end
   end

   // Acks and read data are plain flops so nothing on the AXI side sees a
   // combinational path from its own strobes.
   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         r_wrAck  <= 1'b0;
         r_rdAck  <= 1'b0;
         r_rdData <= '0;
      end else if (w_exec) begin
         r_wrAck <= r_isWrite;
         r_rdAck <= !r_isWrite;
         if (!r_isWrite) begin
            r_rdData <= w_readValue;
         end
      end else if (w_ackDone) begin
         r_wrAck <= 1'b0;
         r_rdAck <= 1'b0;
      end
   end

   // CTRL/STATUS state. A fresh COMMIT wins over the clear from a swap on the
   // same edge so that request is never lost. swap_cnt wraps naturally.
   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         r_bypass        <= 1'b0;
         r_commitPending <= 1'b0;
         r_swapCnt       <= '0;
         r_coeffUpd      <= 1'b0;
      end else begin
         r_coeffUpd <= w_swap;
         if (w_ctrlWr) begin
            r_bypass <= r_wdata[CTRL_BYPASS_BIT];
         end
         if (w_commitWr) begin
            r_commitPending <= 1'b1;
         end else if (w_swap) begin
            r_commitPending <= 1'b0;
         end
         if (w_swap) begin
            r_swapCnt <= r_swapCnt + 8'd1;
         end
      end
   end

   fir_coeff_bank #(
      .NUM_TAPS (NUM_TAPS),
      .COEFF_W  (COEFF_W)
   ) u_bank (
      .i_clk      (s_axi_aclk),
      .i_rstN     (s_axi_aresetn),
      .i_wrEn     (w_tapWr),
      .i_wrIdx    (r_wordAddr[3:0]),
      .i_wrData   (r_wdata[COEFF_W-1:0]),
      .i_swap     (w_swap),
      .i_rdActive (w_activeHit),
      .i_rdIdx    (r_wordAddr[3:0]),
      .o_rdData   (w_bankRd),
      .o_coeff    (coeff_o)
   );

   assign bus.wr_ack_o  = r_wrAck;
   assign bus.rd_ack_o  = r_rdAck;
   assign bus.rd_data_o = r_rdData;
   assign coeff_upd_o   = r_coeffUpd;
   assign bypass_o      = r_bypass;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_coeff_ctrl
// Directed self-checking bench for fir_coeff_ctrl. Requests are driven by
// the main process; each request pushes its expected response onto a
// scoreboard queue that a separate monitor pops on every rising ack.
// ---------------------------------------------------------------------------
module tb_fir_coeff_ctrl;

   localparam int NUM_TAPS = 16;
   localparam int COEFF_W  = 16;

   logic         clk = 1'b0;
   logic         aresetn = 1'b0;
   logic         frameStart = 1'b0;
   logic [255:0] coeff;
   logic         coeffUpd;
   logic         bypass;

   fir_coeff_ctrl_if busIf ();

   fir_coeff_ctrl #(
      .NUM_TAPS (NUM_TAPS),
      .COEFF_W  (COEFF_W)
   ) dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (aresetn),
      .bus           (busIf),
      .frame_start_i (frameStart),
      .coeff_o       (coeff),
      .coeff_upd_o   (coeffUpd),
      .bypass_o      (bypass)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          isWr;
      logic [31:0] data;
      string       tag;
   } expTxn_t;

   expTxn_t     sbQ[$];
   int          vecCount = 0;
   int          missCount = 0;
   logic [15:0] modelShadow [16];
   logic [15:0] modelActive [16];
   int          modelSwaps = 0;

   task automatic checkOutput(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [255:0] packActive();
      logic [255:0] v;
      v = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
         v[k*COEFF_W +: COEFF_W] = modelActive[k];
      end
      return v;
   endfunction

   task automatic modelReset();
      for (int k = 0; k < NUM_TAPS; k++) begin
         modelShadow[k] = (k == 0) ? 16'h4000 : 16'h0000;
         modelActive[k] = (k == 0) ? 16'h4000 : 16'h0000;
      end
      modelSwaps = 0;
   endtask

   task automatic modelSwap();
      for (int k = 0; k < NUM_TAPS; k++) begin
         modelActive[k] = modelShadow[k];
      end
      modelSwaps++;
   endtask

   // Monitor: every rising ack consumes one scoreboard entry.
   task automatic scoreboardPop(input bit isWr, input logic [31:0] data);
      expTxn_t e;
      if (sbQ.size() == 0) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL sbEmpty: ack isWr=%0d seen, expected none", isWr);
      end else begin
         e = sbQ.pop_front();
         checkOutput({e.tag, "-kind"}, 256'(isWr), 256'(e.isWr));
         if (!isWr) begin
            checkOutput(e.tag, 256'(data), 256'(e.data));
         end
      end
   endtask

   initial begin
      logic prevWr;
      logic prevRd;
      prevWr = 1'b0;
      prevRd = 1'b0;
      forever begin
         @(negedge clk);
         if (busIf.wr_ack_o === 1'b1 && !prevWr) scoreboardPop(1'b1, 32'h0);
         if (busIf.rd_ack_o === 1'b1 && !prevRd) scoreboardPop(1'b0, busIf.rd_data_o);
         prevWr = (busIf.wr_ack_o === 1'b1);
         prevRd = (busIf.rd_ack_o === 1'b1);
      end
   end

   task automatic pushExp(input bit isWr, input logic [31:0] expRd, input string tag);
      expTxn_t e;
      e.isWr = isWr;
      e.data = expRd;
      e.tag  = tag;
      sbQ.push_back(e);
   endtask

   task automatic startReq(input bit isWr, input logic [7:0] addr, input logic [31:0] data,
                           input logic [31:0] expRd, input string tag);
      @(posedge clk);
      #1;
      pushExp(isWr, expRd, tag);
      if (isWr) begin
         busIf.wr_addr_i   = addr;
         busIf.wr_data_i   = data;
         busIf.wr_strobe_i = 1'b1;
      end else begin
         busIf.rd_addr_i   = addr;
         busIf.rd_strobe_i = 1'b1;
      end
   endtask

   task automatic waitAck(input bit isWr, input string tag, output int lat);
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((isWr ? busIf.wr_ack_o : busIf.rd_ack_o) === 1'b1) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL %s-ackTimeout: no ack in 20 cycles, expected ack", tag);
      end
   endtask

   task automatic endReq(input bit isWr, input string tag);
      bit seen;
      @(posedge clk);
      #1;
      if (isWr) busIf.wr_strobe_i = 1'b0;
      else      busIf.rd_strobe_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((isWr ? busIf.wr_ack_o : busIf.rd_ack_o) === 1'b0) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         vecCount++;
         missCount++;
         $display("[TB] FAIL %s-releaseTimeout: ack still high, expected low", tag);
      end
   endtask

   // Full four-phase transaction from IDLE; the ack must appear two cycles
   // after the strobe is first presented.
   task automatic applyStimulus(input bit isWr, input logic [7:0] addr, input logic [31:0] data,
                                input logic [31:0] expRd, input string tag);
      int lat;
      startReq(isWr, addr, data, expRd, tag);
      waitAck(isWr, tag, lat);
      checkOutput({tag, "-lat"}, 256'(lat), 256'(2));
      endReq(isWr, tag);
   endtask

   task automatic pulseFrame();
      @(posedge clk);
      #1;
      frameStart = 1'b1;
      @(posedge clk);
      #1;
      frameStart = 1'b0;
   endtask

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int lat;
      busIf.wr_strobe_i = 1'b0;
      busIf.rd_strobe_i = 1'b0;
      busIf.wr_addr_i   = '0;
      busIf.rd_addr_i   = '0;
      busIf.wr_data_i   = '0;
      modelReset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      aresetn = 1'b1;
      @(negedge clk);
      checkOutput("rstWrAck", 256'(busIf.wr_ack_o), 256'(0));
      checkOutput("rstRdAck", 256'(busIf.rd_ack_o), 256'(0));
      checkOutput("rstRdData", 256'(busIf.rd_data_o), 256'(0));
      checkOutput("rstCoeff", coeff, packActive());
      checkOutput("rstUpd", 256'(coeffUpd), 256'(0));
      checkOutput("rstBypass", 256'(bypass), 256'(0));
      applyStimulus(1'b0, 8'h44, '0, 32'h0000_0000, "statusReset");

      // Tap write/readback, active window untouched
      applyStimulus(1'b1, 8'h08, 32'h0000_1234, '0, "wrTap2");
      modelShadow[2] = 16'h1234;
      applyStimulus(1'b0, 8'h08, '0, 32'h0000_1234, "rdTap2");
      applyStimulus(1'b0, 8'h88, '0, 32'h0000_0000, "rdAct2");
      @(negedge clk);
      checkOutput("coeffNoSwap", coeff, packActive());

      // Negative tap, low address bits ignored, commit and swap
      applyStimulus(1'b1, 8'h0C, 32'h0000_8000, '0, "wrTap3");
      modelShadow[3] = 16'h8000;
      applyStimulus(1'b0, 8'h0F, '0, 32'hFFFF_8000, "rdTap3SignExt");
      applyStimulus(1'b1, 8'h40, 32'h0000_0001, '0, "commit1");
      applyStimulus(1'b0, 8'h44, '0, 32'h0000_0001, "statusPending");
      pulseFrame();
      modelSwap();
      @(negedge clk);
      checkOutput("swap1Upd", 256'(coeffUpd), 256'(1));
      checkOutput("swap1Coeff", coeff, packActive());
      @(negedge clk);
      checkOutput("swap1UpdPulse", 256'(coeffUpd), 256'(0));
      applyStimulus(1'b0, 8'h44, '0, 32'h0000_0100, "status1Swap");
      applyStimulus(1'b0, 8'h8C, '0, 32'hFFFF_8000, "rdAct3");

      // CTRL.BYPASS and unmapped addresses
      applyStimulus(1'b1, 8'h40, 32'h0000_0002, '0, "bypassOn");
      @(negedge clk);
      checkOutput("bypassOut", 256'(bypass), 256'(1));
      applyStimulus(1'b0, 8'h40, '0, 32'h0000_0002, "rdCtrl");
      applyStimulus(1'b1, 8'hFC, 32'hDEAD_BEEF, '0, "wrUnmapped");
      applyStimulus(1'b0, 8'hFC, '0, 32'h0000_0000, "rdUnmapped");
      applyStimulus(1'b0, 8'h44, '0, 32'h0000_0100, "statusAfterUnmapped");

      // Both strobes together: write served first, read after RELEASE
      @(posedge clk);
      #1;
      pushExp(1'b1, '0, "bothWr");
      pushExp(1'b0, 32'h0000_0055, "bothRd");
      busIf.wr_addr_i   = 8'h10;
      busIf.wr_data_i   = 32'h0000_0055;
      busIf.rd_addr_i   = 8'h10;
      busIf.wr_strobe_i = 1'b1;
      busIf.rd_strobe_i = 1'b1;
      waitAck(1'b1, "bothWr", lat);
      checkOutput("bothWrLat", 256'(lat), 256'(2));
      checkOutput("bothRdHeld", 256'(busIf.rd_ack_o), 256'(0));
      endReq(1'b1, "bothWr");
      modelShadow[4] = 16'h0055;
      waitAck(1'b0, "bothRd", lat);
      checkOutput("bothRdLat", 256'(lat), 256'(2));
      endReq(1'b0, "bothRd");

      // COMMIT executes on the frame_start edge: no swap this frame
      startReq(1'b1, 8'h40, 32'h0000_0003, '0, "commitRace");
      @(posedge clk);
      #1;
      frameStart = 1'b1;
      @(posedge clk);
      #1;
      frameStart = 1'b0;
      @(negedge clk);
      checkOutput("raceNoUpd", 256'(coeffUpd), 256'(0));
      checkOutput("raceCoeff", coeff, packActive());
      waitAck(1'b1, "commitRace", lat);
      endReq(1'b1, "commitRace");
      applyStimulus(1'b0, 8'h44, '0, 32'h0000_0101, "raceStatus");
      pulseFrame();
      modelSwap();
      @(negedge clk);
      checkOutput("swap2Upd", 256'(coeffUpd), 256'(1));
      checkOutput("swap2Coeff", coeff, packActive());
      applyStimulus(1'b0, 8'h44, '0, 32'h0000_0200, "status2Swap");

      // Tap write executes on the swap edge: swap takes the old shadow value
      applyStimulus(1'b1, 8'h40, 32'h0000_0003, '0, "commit3");
      startReq(1'b1, 8'h14, 32'h0000_0777, '0, "wrTap5Race");
      @(posedge clk);
      #1;
      frameStart = 1'b1;
      @(posedge clk);
      #1;
      frameStart = 1'b0;
      modelSwap();
      modelShadow[5] = 16'h0777;
      @(negedge clk);
      checkOutput("tapRaceUpd", 256'(coeffUpd), 256'(1));
      checkOutput("tapRaceCoeff", coeff, packActive());
      waitAck(1'b1, "wrTap5Race", lat);
      endReq(1'b1, "wrTap5Race");
      applyStimulus(1'b0, 8'h14, '0, 32'h0000_0777, "rdTap5Shadow");
      applyStimulus(1'b0, 8'h94, '0, 32'h0000_0000, "rdAct5Old");
      applyStimulus(1'b0, 8'h44, '0, 32'h0000_0300, "status3Swap");

      // Run swap_cnt up to 256 swaps so it wraps to 0
      for (int i = 3; i < 256; i++) begin
         applyStimulus(1'b1, 8'h40, 32'h0000_0003, '0, "commitLoop");
         pulseFrame();
         modelSwap();
      end
      @(negedge clk);
      checkOutput("loopCoeff", coeff, packActive());
      applyStimulus(1'b0, 8'h44, '0, 32'h0000_0000, "statusWrap");

      // Reset while a write sits in ACK with its strobe held
      startReq(1'b1, 8'h18, 32'h0000_1111, '0, "wrTap6PreRst");
      waitAck(1'b1, "wrTap6PreRst", lat);
      checkOutput("wrTap6PreRstLat", 256'(lat), 256'(2));
      pushExp(1'b1, '0, "wrTap6Reserve");
      @(posedge clk);
      #1;
      aresetn = 1'b0;
      @(posedge clk);
      #1;
      aresetn = 1'b1;
      modelReset();
      @(negedge clk);
      checkOutput("midRstAckLow", 256'(busIf.wr_ack_o), 256'(0));
      checkOutput("midRstCoeff", coeff, packActive());
      checkOutput("midRstBypass", 256'(bypass), 256'(0));
      // Ack lands two cycles after release; the first of those was spent above
      waitAck(1'b1, "wrTap6Reserve", lat);
      checkOutput("reserveLat", 256'(lat), 256'(1));
      endReq(1'b1, "wrTap6Reserve");
      modelShadow[6] = 16'h1111;
      applyStimulus(1'b0, 8'h18, '0, 32'h0000_1111, "rdTap6");
      applyStimulus(1'b0, 8'h08, '0, 32'h0000_0000, "rdTap2AfterRst");
      applyStimulus(1'b0, 8'h00, '0, 32'h0000_4000, "rdTap0AfterRst");
      applyStimulus(1'b0, 8'h44, '0, 32'h0000_0000, "statusAfterRst");

      repeat (2) @(negedge clk);
      checkOutput("sbDrained", 256'(sbQ.size()), 256'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
